dog_stage: RTL and testbench

- Stage directly downstream of the 5x5 separable Gaussian blur. It forms one Difference-of-Gaussian (DoG) plane from two inputs:
  - g_lo: the less-blurred stream, which is also the input of the Gaussian instance.
  - g_hi: that Gaussian instance's blurred output.
- g_hi is centre-aligned 2 lines + 2 pixels behind g_lo. This block delays g_lo by the same amount, subtracts, tracks raster position, and masks border pixels whose 5x5 window left the frame.
- Output feeds the extrema detector.

---
 rtl/dog_stage.sv | 58 +++++
 tb/tb_dog_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dog_stage.sv
// dog_stage: aligns g_lo with the Gaussian output, subtracts, and masks windows that leave the frame.
module dog_stage #(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] g_lo,
  input  logic [7:0] g_hi,
  output logic [8:0] dog,
  output logic       dog_valid,
  output logic [8:0] dog_row,
  output logic [8:0] dog_col,
  output logic       frame_done
);
  localparam int DELAY = 2*WIDTH+2;
  localparam int PW = $clog2(DELAY);
  localparam logic [PW-1:0] P_LAST = PW'(DELAY-1);
  localparam logic [8:0] C_LAST = 9'(WIDTH-1);
  localparam logic [8:0] R_LAST = 9'(HEIGHT-1);
  logic [7:0] r_mem [DELAY];
  logic [PW-1:0] r_wr_ptr;
  logic [8:0] r_col, r_row;
  logic [7:0] w_lo_d;
  logic w_col_wrap, w_last, w_valid;
  assign w_lo_d = r_mem[r_wr_ptr];
  assign w_col_wrap = r_col == C_LAST;
  assign w_last = w_col_wrap && r_row == R_LAST;
  assign w_valid = r_col >= 9'd4 && r_row >= 9'd4;
  // Read-before-write: the old word at the pointer is the sample DELAY accepts ago.
  always_ff @(posedge clk)
    if (clk_en && !rst) r_mem[r_wr_ptr] <= g_lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      dog        <= '0;
      dog_valid  <= 1'b0;
      dog_row    <= '0;
      dog_col    <= '0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      r_wr_ptr   <= r_wr_ptr == P_LAST ? '0 : r_wr_ptr + 1'b1;
      r_col      <= w_col_wrap ? '0 : r_col + 9'd1;
      r_row      <= w_last ? '0 : w_col_wrap ? r_row + 9'd1 : r_row;
      dog        <= {1'b0, g_hi} - {1'b0, w_lo_d};
      dog_valid  <= w_valid;
      dog_row    <= r_row - 9'd2;
      dog_col    <= r_col - 9'd2;
      frame_done <= w_last;
    end else begin
      dog_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dog_stage.sv
// tb_dog_stage: directed-vector bench with a sample-history model of the DoG stage.
module tb_dog_stage;
  localparam int W = 8, H = 6, N = W*H, D = 2*W+2;
  logic clk = 0, rst = 1, clk_en = 0;
  logic [7:0] g_lo = 0, g_hi = 0;
  logic [8:0] dog, dog_row, dog_col;
  logic dog_valid, frame_done;
  dog_stage #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .g_lo(g_lo), .g_hi(g_hi),
    .dog(dog), .dog_valid(dog_valid), .dog_row(dog_row), .dog_col(dog_col),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int n = 0, gidx = 0;
  logic [7:0] hist[$];
  logic [7:0] sq[$];
  logic ev = 0, efd = 0;
  logic [8:0] edog = 0, erow = 0, ecol = 0;
  int vcnt = 0, fdcnt = 0, frow = -1, fcol = -1, lrow = -1, lcol = -1;
  logic [8:0] got [N];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Model: position is the accepted-sample count since reset modulo the frame size;
  // the delayed g_lo is simply the sample D accepts earlier in the history.
  always @(posedge clk) begin : model
    int pos;
    logic sr;
    sr = rst;
    if (rst) begin
      n = 0; hist.delete(); ev = 0; efd = 0;
    end else if (clk_en) begin
      pos = n % N;
      ev = (pos / W >= 4) && (pos % W >= 4);
      efd = pos == N - 1;
      if (ev) begin
        edog = 9'(int'(g_hi) - int'(hist[hist.size() - D]));
        erow = 9'(pos / W - 2);
        ecol = 9'(pos % W - 2);
      end
      hist.push_back(g_lo);
      n++;
    end else begin
      ev = 0; efd = 0;
    end
    #1;
    chk("dog_valid", int'(dog_valid), int'(ev));
    chk("frame_done", int'(frame_done), int'(efd));
    if (sr) begin
      chk("rst_dog", int'(dog), 0);
      chk("rst_row", int'(dog_row), 0);
      chk("rst_col", int'(dog_col), 0);
    end
    if (ev && dog_valid) begin
      chk("dog", int'(dog), int'(edog));
      chk("dog_row", int'(dog_row), int'(erow));
      chk("dog_col", int'(dog_col), int'(ecol));
    end
    if (dog_valid) begin
      vcnt++;
      if (frow < 0) begin frow = int'(dog_row); fcol = int'(dog_col); end
      lrow = int'(dog_row); lcol = int'(dog_col);
      if (dog_row < H && dog_col < W) got[int'(dog_row) * W + int'(dog_col)] = dog;
    end
    if (frame_done) fdcnt++;
  end

  task automatic put(input logic en, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    clk_en = en; g_lo = lo; g_hi = hi;
    if (en) sq.push_back(lo);
  endtask

  task automatic clr();
    vcnt = 0; fdcnt = 0; frow = -1; fcol = -1; lrow = -1; lcol = -1;
    foreach (got[i]) got[i] = '0;
  endtask

  // Raster ramp; g_hi is the bench's own D-sample delay of g_lo, +7 at position inj.
  task automatic ramp(input int first, input int last, input int inj, input int pct);
    logic [7:0] lo, hi;
    for (int p = first; p <= last; p++) begin
      while (pct < 100 && $urandom_range(99) >= pct) put(1'b0, g_lo, g_hi);
      lo = 8'(gidx);
      hi = (sq.size() >= D ? sq[sq.size() - D] : 8'd0) + (p == inj ? 8'd7 : 8'd0);
      put(1'b1, lo, hi);
      gidx++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    clr();
    for (int p = 0; p < N; p++) put(1'b1, 8'd100, 8'd100);
    put(1'b0, 8'd0, 8'd0);
    chk("const_count", vcnt, 8);
    chk("const_first_row", frow, 2);
    chk("const_first_col", fcol, 2);
    chk("const_last_row", lrow, 3);
    chk("const_last_col", lcol, 5);
    chk("const_frame_done", fdcnt, 1);
    chk("const_dog", int'(got[3*W+5]), 0);
    clr();
    ramp(0, N-1, 37, 100);
    put(1'b0, 8'd0, 8'd0);
    chk("ramp_count", vcnt, 8);
    chk("ramp_inj7", int'(got[2*W+3]), 7);
    chk("ramp_zero", int'(got[2*W+2]), 0);
    clr();
    for (int p = 0; p < N; p++) put(1'b1, p == 28 ? 8'd255 : 8'd0, p == 36 ? 8'd255 : 8'd0);
    put(1'b0, 8'd0, 8'd0);
    chk("plus255", int'(got[2*W+2]), 255);
    chk("minus255", int'(got[3*W+4]), 257);
    chk("ext_frame_done", fdcnt, 1);
    clr();
    ramp(0, N-1, -1, 30);
    put(1'b0, 8'd0, 8'd0);
    chk("duty_count", vcnt, 8);
    chk("duty_frame_done", fdcnt, 1);
    chk("duty_dog", int'(got[3*W+5]), 0);
    ramp(0, 28, -1, 100);
    @(negedge clk);
    rst = 1; clk_en = 1; g_lo = 8'd0; g_hi = 8'd0;
    @(negedge clk);
    rst = 0; clk_en = 0;
    clr();
    ramp(0, N-1, -1, 100);
    put(1'b0, 8'd0, 8'd0);
    chk("post_rst_count", vcnt, 8);
    chk("post_rst_first_row", frow, 2);
    chk("post_rst_first_col", fcol, 2);
    chk("post_rst_frame_done", fdcnt, 1);
    repeat (2) put(1'b0, 8'd0, 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
